// File: rtl/midi_note_scheduler.sv
// Chooses the next outstanding program change or key note on/off and streams
// it as a 2- or 3-byte MIDI message to a start/ready byte transmitter.
module midi_note_scheduler #(
  parameter int CHANNEL   = 0,
  parameter int BASE_NOTE = 60,
  parameter int VELOCITY  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key,
  input  logic       ena,
  input  logic [6:0] program_num,
  input  logic [4:0] pitchshift,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, SELECT, SEND, WAIT_LO, WAIT_HI} state_t;

  localparam logic [7:0] CH  = 8'(CHANNEL & 15);
  localparam logic [7:0] VEL = 8'(VELOCITY & 127);

  state_t      state, next_state;
  logic [9:0]  sent_state;
  logic [7:0]  sent_note [10];
  logic [6:0]  sent_prog;
  logic        prog_valid;
  logic [3:0]  rr_ptr;
  logic [7:0]  msg [3];
  logic [1:0]  byte_idx;
  logic        ev_prog;
  logic        ev_on;
  logic [3:0]  ev_key;

  logic        prog_pend;
  logic [9:0]  key_pend;
  logic        any_pend;
  logic        sel_found;
  logic [3:0]  sel_idx;
  logic [4:0]  cand;
  logic [7:0]  note_sum;
  logic [7:0]  note_on;
  logic [1:0]  last_idx;

  assign prog_pend = !prog_valid || (program_num != sent_prog);
  assign key_pend  = key ^ sent_state;
  assign any_pend  = prog_pend || (|key_pend);
  assign note_sum  = 8'(BASE_NOTE) + {4'd0, sel_idx} + {3'd0, pitchshift};
  assign note_on   = (note_sum > 8'd127) ? 8'd127 : note_sum;
  assign last_idx  = ev_prog ? 2'd1 : 2'd2;

  // Round-robin search: first pending key at or after rr_ptr, wrapping 9 -> 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < 10; k++) begin
      cand = 5'(rr_ptr) + 5'(k);
      if (cand >= 5'd10) cand = cand - 5'd10;
      if (!sel_found && key_pend[cand[3:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[3:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (ena && any_pend) next_state = SELECT;
      SELECT:  next_state = (prog_pend || sel_found) ? SEND : IDLE;
      SEND:    if (tx_ready) next_state = WAIT_LO;
      WAIT_LO: if (!tx_ready) next_state = WAIT_HI;
      WAIT_HI: if (tx_ready) next_state = (byte_idx == last_idx) ? IDLE : SEND;
      default: next_state = IDLE;
    endcase
  end

  // Sent-state bookkeeping only changes once the final byte has been accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      sent_state <= '0;
      sent_prog  <= '0;
      prog_valid <= 1'b0;
      rr_ptr     <= '0;
      byte_idx   <= '0;
      ev_prog    <= 1'b0;
      ev_on      <= 1'b0;
      ev_key     <= '0;
      for (int i = 0; i < 10; i++) sent_note[i] <= 8'h00;
      for (int i = 0; i < 3; i++)  msg[i] <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        SELECT: begin
          byte_idx <= 2'd0;
          if (prog_pend) begin
            ev_prog <= 1'b1;
            msg[0]  <= 8'hC0 | CH;
            msg[1]  <= {1'b0, program_num};
            msg[2]  <= 8'h00;
          end else if (sel_found) begin
            ev_prog <= 1'b0;
            ev_key  <= sel_idx;
            ev_on   <= key[sel_idx];
            rr_ptr  <= (sel_idx == 4'd9) ? 4'd0 : sel_idx + 4'd1;
            if (key[sel_idx]) begin
              msg[0] <= 8'h90 | CH;
              msg[1] <= note_on;
              msg[2] <= VEL;
            end else begin
              msg[0] <= 8'h80 | CH;
              msg[1] <= sent_note[sel_idx];
              msg[2] <= 8'h00;
            end
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            tx_data  <= msg[byte_idx];
          end
        end
        WAIT_HI: begin
          if (tx_ready) begin
            if (byte_idx == last_idx) begin
              if (ev_prog) begin
                sent_prog  <= msg[1][6:0];
                prog_valid <= 1'b1;
              end else begin
                sent_state[ev_key] <= ev_on;
                if (ev_on) sent_note[ev_key] <= msg[1];
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_note_scheduler.sv
// Directed bench for midi_note_scheduler: transmitter models capture every
// started byte, and each message is compared against hand-computed bytes.
module tb_midi_note_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] key;
  logic       ena, ena_hi;
  logic [6:0] program_num;
  logic [4:0] pitchshift;
  logic       tx_ready, tx_ready_hi;
  logic       tx_start, tx_start_hi;
  logic [7:0] tx_data, tx_data_hi;
  logic       busy, busy_hi;

  int n_compared;
  int n_mismatched;
  logic [7:0] q_main[$];
  logic [7:0] q_hi[$];

  always #5 clk = ~clk;

  midi_note_scheduler dut (
    .clk(clk), .rst(rst), .key(key), .ena(ena), .program_num(program_num),
    .pitchshift(pitchshift), .tx_ready(tx_ready), .tx_start(tx_start),
    .tx_data(tx_data), .busy(busy)
  );

  midi_note_scheduler #(.BASE_NOTE(120)) dut_hi (
    .clk(clk), .rst(rst), .key(key), .ena(ena_hi), .program_num(program_num),
    .pitchshift(pitchshift), .tx_ready(tx_ready_hi), .tx_start(tx_start_hi),
    .tx_data(tx_data_hi), .busy(busy_hi)
  );

  // Transmitter model: capture the byte, drop ready, come back two cycles later.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tx_start) begin
        q_main.push_back(tx_data);
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  initial begin
    tx_ready_hi = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tx_start_hi) begin
        q_hi.push_back(tx_data_hi);
        tx_ready_hi = 1'b0;
        repeat (2) @(posedge clk);
        #1 tx_ready_hi = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    if (obs !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [9:0] k, input logic [4:0] ps);
    key        = k;
    pitchshift = ps;
  endtask

  function automatic int qsize(input bit hi);
    return hi ? q_hi.size() : q_main.size();
  endfunction

  // Wait for n bytes from the chosen transmitter, compare them, then wait for idle.
  task automatic expectMsg(input string tag, input bit hi, input int n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int waited;
    logic [7:0] ebyte [3];
    logic [7:0] got;
    waited   = 0;
    ebyte[0] = b0;
    ebyte[1] = b1;
    ebyte[2] = b2;
    while (qsize(hi) < n && waited < 2000) begin
      tick();
      waited++;
    end
    checkOutput({tag, " arrived"}, 32'(qsize(hi) >= n), 1);
    for (int i = 0; i < n; i++) begin
      got = 8'hxx;
      if (hi && q_hi.size() > 0) got = q_hi.pop_front();
      else if (!hi && q_main.size() > 0) got = q_main.pop_front();
      checkOutput($sformatf("%s byte%0d", tag, i), got, ebyte[i]);
    end
    if (!hi) begin
      waited = 0;
      while (busy && waited < 200) begin
        tick();
        waited++;
      end
      checkOutput({tag, " idle"}, busy, 0);
    end
  endtask

  initial begin
    int waited;
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b1;
    ena          = 1'b1;
    ena_hi       = 1'b0;
    program_num  = 7'd5;
    applyStimulus(10'h000, 5'd0);
    repeat (3) tick();
    checkOutput("reset tx_start", tx_start, 0);
    checkOutput("reset tx_data", tx_data, 0);
    checkOutput("reset busy", busy, 0);
    rst = 1'b0;

    expectMsg("prog change", 0, 2, 8'hC0, 8'h05, 8'h00);
    repeat (40) tick();
    checkOutput("quiet queue", q_main.size(), 0);
    checkOutput("quiet busy", busy, 0);

    $display("[TB] toggle while disabled");
    ena = 1'b0;
    applyStimulus(10'h002, 5'd0);
    repeat (3) tick();
    applyStimulus(10'h000, 5'd0);
    tick();
    ena = 1'b1;
    repeat (30) tick();
    checkOutput("toggle no msg", q_main.size(), 0);

    applyStimulus(10'h004, 5'd0);
    repeat (2) tick();
    checkOutput("busy during msg", busy, 1);
    expectMsg("key2 on", 0, 3, 8'h90, 8'h3E, 8'h64);
    applyStimulus(10'h000, 5'd0);
    expectMsg("key2 off", 0, 3, 8'h80, 8'h3E, 8'h00);

    $display("[TB] note-off after pitchshift change");
    applyStimulus(10'h008, 5'd0);
    expectMsg("key3 on", 0, 3, 8'h90, 8'h3F, 8'h64);
    applyStimulus(10'h008, 5'd4);
    repeat (10) tick();
    checkOutput("pitch change no msg", q_main.size(), 0);
    applyStimulus(10'h000, 5'd4);
    expectMsg("key3 off", 0, 3, 8'h80, 8'h3F, 8'h00);

    $display("[TB] key 9 with pitchshift 31, plus clamped instance");
    applyStimulus(10'h200, 5'd31);
    ena_hi = 1'b1;
    expectMsg("key9 on", 0, 3, 8'h90, 8'h64, 8'h64);
    expectMsg("hi prog", 1, 2, 8'hC0, 8'h05, 8'h00);
    expectMsg("hi key9 clamp", 1, 3, 8'h90, 8'h7F, 8'h64);
    ena_hi = 1'b0;
    applyStimulus(10'h000, 5'd0);
    expectMsg("key9 off", 0, 3, 8'h80, 8'h64, 8'h00);

    $display("[TB] all keys at once");
    applyStimulus(10'h3FF, 5'd0);
    for (int i = 0; i < 10; i++)
      expectMsg($sformatf("all on %0d", i), 0, 3, 8'h90, 8'(60 + i), 8'h64);
    applyStimulus(10'h3EF, 5'd0);
    expectMsg("key4 off", 0, 3, 8'h80, 8'h40, 8'h00);
    applyStimulus(10'h36B, 5'd0);
    expectMsg("rr key7 off", 0, 3, 8'h80, 8'h43, 8'h00);
    expectMsg("rr key2 off", 0, 3, 8'h80, 8'h3E, 8'h00);

    $display("[TB] reset in the middle of a message");
    applyStimulus(10'h34B, 5'd0);
    waited = 0;
    while (q_main.size() < 2 && waited < 2000) begin
      tick();
      waited++;
    end
    checkOutput("second byte started", tx_start, 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst tx_start", tx_start, 0);
    checkOutput("midrst tx_data", tx_data, 0);
    checkOutput("midrst busy", busy, 0);
    q_main.delete();
    applyStimulus(10'h001, 5'd0);
    repeat (4) tick();
    rst = 1'b0;
    expectMsg("post-reset prog", 0, 2, 8'hC0, 8'h05, 8'h00);
    expectMsg("post-reset key0", 0, 3, 8'h90, 8'h3C, 8'h64);
    repeat (30) tick();
    checkOutput("post-reset quiet", q_main.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
